// File: rtl/dm_dump_reader.sv
// dm_dump_reader: reads DEPTH_WORDS little-endian words from a byte-wide data memory and streams them out.
// Define DUMP_CHECKSUM_EN to append one XOR-checksum beat after the data words.
module dm_dump_reader #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned DEPTH_WORDS = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              dm_rd,
    output logic [ADDR_W-1:0] dm_addr,
    input  logic [7:0]        dm_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam int unsigned       WC_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [WC_W-1:0]   LAST_WORD = WC_W'(DEPTH_WORDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CAPT, S_PUSH, S_DONE} state_t;

    state_t            state_q;
    logic [1:0]        byte_cnt_q;
    logic [WC_W-1:0]   word_cnt_q;
    logic [ADDR_W-1:0] word_addr_q;
    logic [ADDR_W-1:0] dm_addr_q;
    logic [31:0]       asm_q;
    logic              dm_rd_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              busy_q;
    logic              done_q;
`ifdef DUMP_CHECKSUM_EN
    logic [31:0]       csum_q;
    logic              csum_beat_q;
`endif

    logic [1:0]        byte_cnt_d;
    logic [ADDR_W-1:0] word_addr_d;
    logic [31:0]       asm_d;

    // NOTE: combinational next-state uses blocking '=' with every output defaulted first, so no latch is inferred.
    always_comb begin
        byte_cnt_d  = byte_cnt_q + 2'd1;
        word_addr_d = word_addr_q + ADDR_W'(4);
        asm_d       = asm_q;
        asm_d[{byte_cnt_q, 3'b000} +: 8] = dm_rdata;
    end

    // NOTE: all state and outputs are registered with non-blocking '<=' so every read sees the pre-edge value.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            word_addr_q <= '0;
            dm_addr_q   <= '0;
            asm_q       <= '0;
            dm_rd_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum_q      <= '0;
            csum_beat_q <= 1'b0;
`endif
        end else begin
            dm_rd_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_ISSUE;
                        busy_q      <= 1'b1;
                        byte_cnt_q  <= '0;
                        word_cnt_q  <= '0;
                        word_addr_q <= BASE;
                        dm_addr_q   <= BASE;
                        dm_rd_q     <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        csum_q      <= '0;
                        csum_beat_q <= 1'b0;
`endif
                    end
                end
                S_ISSUE: state_q <= S_CAPT;
                S_CAPT: begin
                    asm_q <= asm_d;
                    if (byte_cnt_q != 2'd3) begin
                        byte_cnt_q <= byte_cnt_d;
                        dm_addr_q  <= word_addr_q + ADDR_W'(byte_cnt_d);
                        dm_rd_q    <= 1'b1;
                        state_q    <= S_ISSUE;
                    end else begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_PUSH;
`ifdef DUMP_CHECKSUM_EN
                        out_last_q  <= 1'b0;
`else
                        out_last_q  <= (word_cnt_q == LAST_WORD);
`endif
                    end
                end
                S_PUSH: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (word_cnt_q != LAST_WORD) begin
                            word_cnt_q  <= word_cnt_q + WC_W'(1);
                            word_addr_q <= word_addr_d;
                            dm_addr_q   <= word_addr_d;
                            byte_cnt_q  <= '0;
                            dm_rd_q     <= 1'b1;
                            state_q     <= S_ISSUE;
`ifdef DUMP_CHECKSUM_EN
                            csum_q      <= csum_q ^ asm_q;
`endif
                        end
`ifdef DUMP_CHECKSUM_EN
                        // Final data word just left: reuse the word register for the checksum beat.
                        else if (!csum_beat_q) begin
                            csum_beat_q <= 1'b1;
                            asm_q       <= csum_q ^ asm_q;
                            word_addr_q <= BASE;
                            out_valid_q <= 1'b1;
                            out_last_q  <= 1'b1;
                        end
`endif
                        else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dm_rd     = dm_rd_q;
    assign dm_addr   = dm_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = asm_q;
    assign out_addr  = word_addr_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule
